processador_multiciclo: RTL and testbench

Parametrised multi-cycle successor to the team's 8-bit single-cycle processor.
- Datapath width and address width are generics.
- Instructions execute through a fetch/decode/execute state machine.
- A single unified memory port with a req/ack handshake replaces separate instruction and data memories, so the block tolerates wait states.
- Sits at the top of the CPU subsystem; an external RAM/ROM model sits on the memory port.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/banco_reg_p.sv | 42 ++++
 rtl/processador_multiciclo.sv | 224 ++++++++++++++++++++++
 tb/tb_processador_multiciclo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, FSM state codes
// and bit positions of the 8-bit instruction word.
package proc_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_MOV = 4'h5;
   localparam logic [3:0] OP_LDI = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_BEQ = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int IR_W   = 8;
   localparam int OP_MSB = 7;
   localparam int OP_LSB = 4;
   localparam int RA_MSB = 3;
   localparam int RA_LSB = 2;
   localparam int RB_MSB = 1;
   localparam int RB_LSB = 0;

   typedef logic [2:0] state_t;

   localparam state_t ST_FETCH  = 3'd0;
   localparam state_t ST_DECODE = 3'd1;
   localparam state_t ST_FETCH2 = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_MEM    = 3'd4;
   localparam state_t ST_HALT   = 3'd5;

   // LDI, LD, ST, JMP and BEQ carry a second operand word.
   function automatic logic has_operand(input logic [3:0] op);
      return (op >= OP_LDI) && (op <= OP_BEQ);
   endfunction

   function automatic logic updates_flag(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_OR);
   endfunction

endpackage

// File: rtl/banco_reg_p.sv
// Four-entry register file: two combinational read ports, one synchronous
// write port, r3 exported for the board display.
module banco_reg_p #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        raddr_a,
   input  logic [1:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [1:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] r3
);

   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];
   assign r3      = regs_q[3];

endmodule

// File: rtl/processador_multiciclo.sv
// Multi-cycle processor: fetch/decode/execute FSM over one unified memory
// port with a req/ack handshake, so the memory may insert wait states.
module processador_multiciclo
   import proc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic [DATA_W-1:0] dbg_r3
);

   localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0] opr_q, opr_d;
   logic              z_q, z_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              halted_q, halted_d;

   logic [3:0]        op;
   logic [1:0]        ra, rb;
   logic [DATA_W-1:0] rd_a, rd_b, alu_res;
   logic [ADDR_W-1:0] pc_inc, opr_addr;
   logic              acked;
   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;

   assign op       = ir_q[OP_MSB:OP_LSB];
   assign ra       = ir_q[RA_MSB:RA_LSB];
   assign rb       = ir_q[RB_MSB:RB_LSB];
   assign pc_inc   = pc_q + PC_ONE;
   assign opr_addr = opr_q[ADDR_W-1:0];
   assign acked    = mem_req_q & mem_ack;

   banco_reg_p #(
      .DATA_W(DATA_W)
   ) u_rf (
      .clk    (clk),
      .reset  (reset),
      .raddr_a(ra),
      .raddr_b(rb),
      .rdata_a(rd_a),
      .rdata_b(rd_b),
      .we     (rf_we),
      .waddr  (ra),
      .wdata  (rf_wdata),
      .r3     (dbg_r3)
   );

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = rd_a + rd_b;
         OP_SUB:  alu_res = rd_a - rd_b;
         OP_AND:  alu_res = rd_a & rd_b;
         OP_OR:   alu_res = rd_a | rd_b;
         OP_MOV:  alu_res = rd_b;
         OP_LDI:  alu_res = opr_q;
         default: alu_res = '0;
      endcase
   end

   // Bus outputs are registered, so each transition also sets up the
   // request belonging to the state being entered.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      opr_d       = opr_q;
      z_d         = z_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      halted_d    = halted_q;
      rf_we       = 1'b0;
      rf_wdata    = alu_res;

      case (state_q)
         ST_FETCH: begin
            if (!mem_req_q) begin
               // Only reached straight out of reset: launch the first fetch.
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = pc_q;
            end else if (mem_ack) begin
               ir_d      = mem_rdata[IR_W-1:0];
               pc_d      = pc_inc;
               mem_req_d = 1'b0;
               state_d   = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (has_operand(op)) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = pc_q;
               state_d    = ST_FETCH2;
            end else if (op == OP_HLT) begin
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_FETCH2: begin
            if (acked) begin
               opr_d     = mem_rdata;
               pc_d      = pc_inc;
               mem_req_d = 1'b0;
               state_d   = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LDI: begin
                  rf_we = 1'b1;
                  if (updates_flag(op)) begin
                     z_d = (alu_res == '0);
                  end
               end
               OP_JMP: begin
                  pc_d       = opr_addr;
                  mem_addr_d = opr_addr;
               end
               OP_BEQ: begin
                  if (rd_a == rd_b) begin
                     pc_d       = opr_addr;
                     mem_addr_d = opr_addr;
                  end
               end
               OP_LD, OP_ST: begin
                  state_d    = ST_MEM;
                  mem_addr_d = opr_addr;
                  mem_we_d   = (op == OP_ST);
                  if (op == OP_ST) begin
                     mem_wdata_d = rd_a;
                  end
               end
               default: ;
            endcase
         end

         ST_MEM: begin
            if (acked) begin
               if (!mem_we_q) begin
                  rf_we    = 1'b1;
                  rf_wdata = mem_rdata;
               end
               state_d    = ST_FETCH;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = pc_q;
            end
         end

         ST_HALT: begin
            mem_req_d = 1'b0;
            halted_d  = 1'b1;
         end

         default: begin
            state_d   = ST_FETCH;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         opr_q       <= '0;
         z_q         <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         opr_q       <= opr_d;
         z_q         <= z_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         halted_q    <= halted_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign pc        = pc_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_processador_multiciclo.sv
// Directed bench for processador_multiciclo: an 8/8 core and a 16/8 core,
// each with a behavioural memory that can insert wait states.
module tb_processador_multiciclo;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- DUT A: DATA_W=8, ADDR_W=8 ----------------
   logic       rst_a;
   logic       mem_req_a, mem_we_a, halted_a;
   logic [7:0] mem_addr_a, mem_wdata_a, pc_a, dbg_r3_a;
   logic [7:0] mem_rdata_a = 8'hEE;
   logic       mem_ack_a   = 1'b0;

   processador_multiciclo #(.DATA_W(8), .ADDR_W(8)) dut_a (
      .clk      (clk),
      .reset    (rst_a),
      .mem_req  (mem_req_a),
      .mem_we   (mem_we_a),
      .mem_addr (mem_addr_a),
      .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a),
      .mem_ack  (mem_ack_a),
      .pc       (pc_a),
      .halted   (halted_a),
      .dbg_r3   (dbg_r3_a)
   );

   logic [7:0] mem_a [256];
   logic [7:0] log_a [$];
   int         wait_a = 0;
   int         wcnt_a = 0;
   int         unstable_a = 0;
   int         wr_cnt_a = 0;
   logic [7:0] wr_addr_a = 8'h00;
   logic [7:0] wr_data_a = 8'h00;
   logic [7:0] sav_addr_a, sav_wdata_a;
   logic       sav_we_a;

   // Memory A: acks after wait_a wait cycles, logs every completed access.
   always @(negedge clk) begin
      if (mem_req_a) begin
         if (wcnt_a == 0) begin
            sav_addr_a  = mem_addr_a;
            sav_we_a    = mem_we_a;
            sav_wdata_a = mem_wdata_a;
         end else if (mem_addr_a !== sav_addr_a || mem_we_a !== sav_we_a ||
                      mem_wdata_a !== sav_wdata_a) begin
            unstable_a++;
         end
         if (wcnt_a >= wait_a) begin
            mem_ack_a = 1'b1;
            if (mem_we_a) begin
               mem_a[mem_addr_a] = mem_wdata_a;
               wr_cnt_a++;
               wr_addr_a   = mem_addr_a;
               wr_data_a   = mem_wdata_a;
               mem_rdata_a = 8'hEE;
            end else begin
               mem_rdata_a = mem_a[mem_addr_a];
            end
            log_a.push_back(mem_addr_a);
            wcnt_a = 0;
         end else begin
            mem_ack_a   = 1'b0;
            mem_rdata_a = 8'hEE;
            wcnt_a++;
         end
      end else begin
         mem_ack_a   = 1'b0;
         mem_rdata_a = 8'hEE;
         wcnt_a      = 0;
      end
   end

   // ---------------- DUT B: DATA_W=16, ADDR_W=8 ----------------
   logic        rst_b;
   logic        mem_req_b, mem_we_b, halted_b;
   logic [7:0]  mem_addr_b, pc_b;
   logic [15:0] mem_wdata_b, dbg_r3_b;
   logic [15:0] mem_rdata_b = 16'hEEEE;
   logic        mem_ack_b   = 1'b0;

   processador_multiciclo #(.DATA_W(16), .ADDR_W(8)) dut_b (
      .clk      (clk),
      .reset    (rst_b),
      .mem_req  (mem_req_b),
      .mem_we   (mem_we_b),
      .mem_addr (mem_addr_b),
      .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b),
      .mem_ack  (mem_ack_b),
      .pc       (pc_b),
      .halted   (halted_b),
      .dbg_r3   (dbg_r3_b)
   );

   logic [15:0] mem_b [256];

   always @(negedge clk) begin
      if (mem_req_b) begin
         mem_ack_b = 1'b1;
         if (mem_we_b) begin
            mem_b[mem_addr_b] = mem_wdata_b;
            mem_rdata_b = 16'hEEEE;
         end else begin
            mem_rdata_b = mem_b[mem_addr_b];
         end
      end else begin
         mem_ack_b   = 1'b0;
         mem_rdata_b = 16'hEEEE;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic prep_a(input int waits);
      rst_a = 1'b0;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
      log_a.delete();
      wr_cnt_a   = 0;
      unstable_a = 0;
      wait_a     = waits;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_a();
      @(negedge clk);
      rst_a = 1'b1;
   endtask

   // Cycle index at which halted is first seen, counting the first cycle
   // with mem_req high as cycle 1; -1 if the budget runs out.
   task automatic run_until_halt(input bit sel_b, input int budget, output int idx);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      idx  = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!seen && (sel_b ? mem_req_b : mem_req_a)) seen = 1'b1;
         if (seen) n++;
         if (sel_b ? halted_b : halted_a) begin
            idx = n;
            break;
         end
      end
   endtask

   int hidx;
   bit found;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      for (int i = 0; i < 256; i++) mem_b[i] = 16'h0000;

      // ---- reset state ----
      prep_a(0);
      check("rst_mem_req", mem_req_a, 0);
      check("rst_mem_we", mem_we_a, 0);
      check("rst_mem_addr", mem_addr_a, 0);
      check("rst_mem_wdata", mem_wdata_a, 0);
      check("rst_pc", pc_a, 0);
      check("rst_halted", halted_a, 0);
      check("rst_dbg_r3", dbg_r3_a, 0);

      // ---- T1: LDI r0,5; LDI r1,3; ADD r0,r1; HLT (zero wait) ----
      mem_a[0] = 8'h60; mem_a[1] = 8'h05;
      mem_a[2] = 8'h64; mem_a[3] = 8'h03;
      mem_a[4] = 8'h11; mem_a[5] = 8'hF0;
      release_a();
      @(negedge clk);
      check("t1_first_req", mem_req_a, 1);
      check("t1_first_addr", mem_addr_a, 0);
      rst_a = 1'b0;
      release_a();
      // LDI 4 + LDI 4 + ADD 3 + HLT fetch/decode 2 cycles, halted in cycle 14
      run_until_halt(1'b0, 60, hidx);
      check("t1_halt_cycle", hidx, 14);
      check("t1_r0", dut_a.u_rf.regs_q[0], 8'h08);
      check("t1_z", dut_a.z_q, 0);
      check("t1_pc", pc_a, 8'h06);
      @(negedge clk);
      check("t1_req_after_halt", mem_req_a, 0);

      // ---- T2: LDI r0,9; SUB r0,r0; BEQ r2,r3,0x20; HLT@0x20 ----
      prep_a(0);
      mem_a[0] = 8'h60; mem_a[1] = 8'h09;
      mem_a[2] = 8'h20;
      mem_a[3] = 8'hAB; mem_a[4] = 8'h20;
      mem_a[8'h20] = 8'hF0;
      release_a();
      run_until_halt(1'b0, 60, hidx);
      check("t2_halt_cycle", hidx, 14);
      check("t2_r0", dut_a.u_rf.regs_q[0], 8'h00);
      check("t2_z", dut_a.z_q, 1);
      check("t2_log_len", log_a.size(), 6);
      if (log_a.size() >= 6) check("t2_branch_fetch", log_a[5], 8'h20);
      check("t2_pc", pc_a, 8'h21);

      // ---- T3: LDI r1,3; ST r1,[40]; LD r2,[40]; MOV r3,r2; HLT, 2 waits ----
      prep_a(2);
      mem_a[0] = 8'h64; mem_a[1] = 8'h03;
      mem_a[2] = 8'h84; mem_a[3] = 8'h40;
      mem_a[4] = 8'h78; mem_a[5] = 8'h40;
      mem_a[6] = 8'h5E; mem_a[7] = 8'hF0;
      release_a();
      // zero-wait 19 cycles + 10 accesses x 2 waits, halted in cycle 40
      run_until_halt(1'b0, 120, hidx);
      check("t3_halt_cycle", hidx, 40);
      check("t3_wr_count", wr_cnt_a, 1);
      check("t3_wr_addr", wr_addr_a, 8'h40);
      check("t3_wr_data", wr_data_a, 8'h03);
      check("t3_mem40", mem_a[8'h40], 8'h03);
      check("t3_r2", dut_a.u_rf.regs_q[2], 8'h03);
      check("t3_dbg_r3", dbg_r3_a, 8'h03);
      check("t3_stable", unstable_a, 0);

      // ---- T4a: JMP 0xFF; NOP at 0xFF wraps to 0x00 ----
      prep_a(0);
      mem_a[0] = 8'h90; mem_a[1] = 8'hFF;
      mem_a[8'hFF] = 8'h00;
      release_a();
      repeat (14) @(negedge clk);
      check("t4a_log_len", log_a.size() >= 4, 1);
      if (log_a.size() >= 4) begin
         check("t4a_nop_fetch", log_a[2], 8'hFF);
         check("t4a_wrap_fetch", log_a[3], 8'h00);
      end

      // ---- T4b: JMP at 0xFE with OPR at 0xFF -> 0x10 ----
      prep_a(0);
      mem_a[0] = 8'h90; mem_a[1] = 8'hFE;
      mem_a[8'hFE] = 8'h90; mem_a[8'hFF] = 8'h10;
      mem_a[8'h10] = 8'hF0;
      release_a();
      run_until_halt(1'b0, 60, hidx);
      check("t4b_halted", hidx > 0, 1);
      check("t4b_log_len", log_a.size(), 5);
      if (log_a.size() >= 5) check("t4b_target_fetch", log_a[4], 8'h10);
      check("t4b_pc", pc_a, 8'h11);

      // ---- T5: MOV/AND/OR and a BEQ not taken ----
      prep_a(0);
      mem_a[0] = 8'h60; mem_a[1] = 8'h0C;
      mem_a[2] = 8'h64; mem_a[3] = 8'h0A;
      mem_a[4] = 8'h5C; mem_a[5] = 8'h3D; mem_a[6] = 8'h41;
      mem_a[7] = 8'hA1; mem_a[8] = 8'h30;
      mem_a[9] = 8'hF0;
      release_a();
      run_until_halt(1'b0, 80, hidx);
      check("t5_halt_cycle", hidx, 24);
      check("t5_r3_and", dbg_r3_a, 8'h08);
      check("t5_r0_or", dut_a.u_rf.regs_q[0], 8'h0E);
      check("t5_z", dut_a.z_q, 0);
      check("t5_pc", pc_a, 8'h0A);

      // ---- T6: reset during a MEM wait state ----
      prep_a(4);
      mem_a[0] = 8'h64; mem_a[1] = 8'h03;
      mem_a[2] = 8'h84; mem_a[3] = 8'h40;
      release_a();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_we_a) begin
            found = 1'b1;
            break;
         end
      end
      check("t6_store_seen", found, 1);
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      check("t6_req_async", mem_req_a, 0);
      check("t6_we_async", mem_we_a, 0);
      check("t6_addr_async", mem_addr_a, 0);
      check("t6_pc_async", pc_a, 0);
      check("t6_r1_async", dut_a.u_rf.regs_q[1], 0);
      wait_a = 0;
      repeat (2) @(negedge clk);
      log_a.delete();
      release_a();
      @(negedge clk);
      check("t6_restart_req", mem_req_a, 1);
      check("t6_restart_addr", mem_addr_a, 0);
      check("t6_restart_r3", dbg_r3_a, 0);

      // ---- T7: 16-bit core, LDI r3,FFFF; LDI r1,1; ADD r3,r1; HLT ----
      mem_b[0] = 16'hA56C; mem_b[1] = 16'hFFFF;
      mem_b[2] = 16'h5A64; mem_b[3] = 16'h0001;
      mem_b[4] = 16'h001D; mem_b[5] = 16'h00F0;
      @(negedge clk);
      rst_b = 1'b1;
      run_until_halt(1'b1, 60, hidx);
      check("t7_halt_cycle", hidx, 14);
      check("t7_dbg_r3", dbg_r3_b, 16'h0000);
      check("t7_z", dut_b.z_q, 1);
      check("t7_r1", dut_b.u_rf.regs_q[1], 16'h0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
